urem_ic_search: RTL and testbench
=================================

# urem_ic_search

Sequential, width-parametrised Skolem-witness engine for the bit-vector constraint `(x urem s) CMP t`, where `x` is the unknown. For operands `s` and `t` it decides whether a witness `x` exists and returns the smallest one. It works by exhaustive ascending enumeration, using a restoring remainder datapath. It is the clocked, multi-width, multi-predicate successor to the fixed 4-bit combinational bvsge/bvurem Skolem function. It sits behind the solver-side request queue and gives a ground witness that is checked against the combinational invertibility condition.

## Interface
- `W`, default 4: operand width in bits; legal range 2..12 (search time grows as 2^W).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: engine idle and able to accept a request.
- `req_s` in W: divisor `s`.
- `req_t` in W: comparison bound `t`.
- `req_mode` in 2: predicate select.
  - 00: signed `>=` (bvsge)
  - 01: signed `>` (bvsgt)
  - 10: unsigned `>=` (bvuge)
  - 11: unsigned `>` (bvugt)
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_sat` out 1: 1 if a witness exists.
- `res_x` out W: smallest witness `x`; 0 when `res_sat`=0.
- `res_iters` out W+1: number of candidates evaluated, 1..2^W.

## Operation
- FSM states: IDLE, DIV, CMP, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid&&req_ready`, latch `s`, `t` and mode, clear `x`, clear the remainder `r` (W+1 bits) and clear the bit counter `k`, then go to DIV.
- DIV: one restoring step per cycle, `x` scanned MSB first.
  - `r' = {r[W-1:0], x[W-1-k]}`; if `r' >= {1'b0,s}` then `r = r' - s`, else `r = r'`.
  - After W steps, go to CMP.
  - SMT-LIB semantics follow with no special case: when `s`=0, the result is `x urem 0 = x`.
- CMP: compare `r[W-1:0]` against `t` using the latched mode.
  - Hit: `res_sat`=1, `res_x`=x, go to DONE.
  - Miss with `x` = all-ones: `res_sat`=0, `res_x`=0, go to DONE.
  - Otherwise: `x` = x+1, clear `r` and `k`, return to DIV.
  - `res_iters` = x+1 at the exit point; it is W+1 bits wide so that 2^W does not wrap.
- DONE:
  - `res_valid`=1, and all result fields are held stable until `res_ready`.
  - On `res_valid&&res_ready`, go to IDLE.
- A request arriving while busy is not accepted: `req_ready`=0 in DIV, CMP and DONE.
- Signed comparisons treat both `r[W-1:0]` and `t` as two's complement.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - `req_ready`=1.
  - `res_valid`=0, `res_sat`=0, `res_x`=0, `res_iters`=0.
  - All internal registers cleared.
- Take the accepting edge as edge 0. For a hit on candidate index n, `res_valid` rises after edge (W+1)·(n+1).
- Unsat latency is (W+1)·2^W edges.
- `req_ready` falls after edge 0 and rises again on the edge after the result handshake.
- `req_ready` is 0 in the same cycle that `res_valid` is 1. Back-to-back throughput is therefore one request per result handshake plus one IDLE cycle.
- `res_ready` held low stalls DONE indefinitely. Result outputs do not change while stalled.
- Asserting `rst_n` low mid-search aborts the search immediately. No `res_valid` pulse is produced, and the engine is ready in the first cycle after release.
- `res_ready` asserted while `res_valid`=0 has no effect.

## Test plan
All scenarios use W=4.
- Reset mid-search:
  - Issue s=4, t=7, mode=00.
  - Pull `rst_n` low after 10 edges.
  - Expect `res_valid` never pulses.
  - Expect all outputs at reset values and `req_ready`=1 after release.
  - A following request s=3, t=2 returns x=2.
- Basic signed hit: s=3, t=2, mode=00 → `res_sat`=1, `res_x`=2, `res_iters`=3, `res_valid` after edge 15.
- Divide by zero: s=0, t=5, mode=00 → x=5, iters=6, edge 30; with mode=01 → x=6.
- Immediate hit: s=5, t=4'b1000 (−8), mode=00 → x=0, iters=1, `res_valid` after edge 5.
- Unsat cases:
  - s=4, t=7, mode=00 (max remainder is 3) → `res_sat`=0, `res_x`=0, iters=16, `res_valid` after edge 80.
  - s=9, t=15, mode=11 → unsat.
- Backpressure:
  - Hold `res_ready`=0 for 20 cycles after `res_valid`.
  - Expect fields stable, `req_ready`=0, and a `req_valid` pulse ignored.
  - On release, expect one IDLE cycle, then the next request accepted.

Source files
------------

// File: rtl/urem_ic_search.sv
// urem_ic_search: sequential Skolem-witness engine for (x urem s) CMP t.
// Enumerates x = 0,1,2,... and computes x urem s with a restoring divider
// (one quotient bit per cycle, MSB first). The first x whose remainder
// satisfies the selected predicate is returned. If none exists, unsat is
// reported after all 2^W candidates have been tried.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   req_s, req_t, req_mode  divisor, bound, predicate
//                           (00 sge, 01 sgt, 10 uge, 11 ugt)
//   res_valid/res_ready     result handshake (fields held while stalled)
//   res_sat, res_x          witness found / smallest witness (0 if unsat)
//   res_iters               candidates evaluated, 1..2^W
module urem_ic_search #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_s,
  input  logic [W-1:0] req_t,
  input  logic [1:0]   req_mode,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_sat,
  output logic [W-1:0] res_x,
  output logic [W:0]   res_iters
);

  localparam int KW = $clog2(W);

  typedef enum logic [1:0] {IDLE, DIV, CMP, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   s_q, s_d, t_q, t_d;
  logic [1:0]     mode_q, mode_d;
  logic [W-1:0]   x_q, x_d;
  // copy of x shifted left once per step so the next dividend bit is
  // always at the MSB; avoids a variable bit select on x
  logic [W-1:0]   xs_q, xs_d;
  logic [W:0]     r_q, r_d;
  logic [KW-1:0]  k_q, k_d;
  logic           sat_q, sat_d;
  logic [W-1:0]   rx_q, rx_d;
  logic [W:0]     iters_q, iters_d;

  logic [W:0]     r_shift, r_sub;
  logic           hit;

  always_comb begin
    r_shift = {r_q[W-1:0], xs_q[W-1]};
    r_sub   = r_shift - {1'b0, s_q};
    unique case (mode_q)
      2'b00:   hit = $signed(r_q[W-1:0]) >= $signed(t_q);
      2'b01:   hit = $signed(r_q[W-1:0]) >  $signed(t_q);
      2'b10:   hit = r_q[W-1:0] >= t_q;
      default: hit = r_q[W-1:0] >  t_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    mode_d  = mode_q;
    x_d     = x_q;
    xs_d    = xs_q;
    r_d     = r_q;
    k_d     = k_q;
    sat_d   = sat_q;
    rx_d    = rx_q;
    iters_d = iters_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          s_d     = req_s;
          t_d     = req_t;
          mode_d  = req_mode;
          x_d     = '0;
          xs_d    = '0;
          r_d     = '0;
          k_d     = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        // s = 0 needs no special case: every step subtracts zero, so r ends as x
        r_d  = (r_shift >= {1'b0, s_q}) ? r_sub : r_shift;
        xs_d = xs_q << 1;
        k_d  = k_q + KW'(1);
        if (k_q == KW'(W-1)) begin
          k_d     = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (hit || (&x_q)) begin
          sat_d   = hit;
          rx_d    = hit ? x_q : '0;
          iters_d = {1'b0, x_q} + (W+1)'(1);
          state_d = DONE;
        end else begin
          x_d     = x_q + W'(1);
          xs_d    = x_q + W'(1);
          r_d     = '0;
          k_d     = '0;
          state_d = DIV;
        end
      end
      default: begin
        if (res_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      t_q     <= '0;
      mode_q  <= '0;
      x_q     <= '0;
      xs_q    <= '0;
      r_q     <= '0;
      k_q     <= '0;
      sat_q   <= 1'b0;
      rx_q    <= '0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      xs_q    <= xs_d;
      r_q     <= r_d;
      k_q     <= k_d;
      sat_q   <= sat_d;
      rx_q    <= rx_d;
      iters_q <= iters_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign res_sat   = sat_q;
  assign res_x     = rx_q;
  assign res_iters = iters_q;

endmodule

// File: tb/tb_urem_ic_search.sv
module tb_urem_ic_search;
  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         req_valid = 0;
  logic         req_ready;
  logic [W-1:0] req_s = '0, req_t = '0;
  logic [1:0]   req_mode = '0;
  logic         res_valid;
  logic         res_ready = 0;
  logic         res_sat;
  logic [W-1:0] res_x;
  logic [W:0]   res_iters;

  int errors = 0;
  int checks = 0;

  urem_ic_search #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_t(req_t), .req_mode(req_mode),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sat(res_sat), .res_x(res_x), .res_iters(res_iters)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: brute-force search using plain integer arithmetic.
  function automatic void ref_model(input int s, input int t, input int mode,
                                    output int sat, output int x, output int it);
    int rem, rv, tv;
    sat = 0; x = 0; it = N;
    for (int c = 0; c < N; c++) begin
      rem = (s == 0) ? c : c % s;
      if (mode < 2) begin
        rv = (rem >= N/2) ? rem - N : rem;
        tv = (t   >= N/2) ? t   - N : t;
      end else begin
        rv = rem; tv = t;
      end
      if ((mode[0] == 1'b0) ? (rv >= tv) : (rv > tv)) begin
        sat = 1; x = c; it = c + 1;
        return;
      end
    end
  endfunction

  // Cycle-level expectation: busy from acceptance, result appears
  // (W+1)*iters edges later, stays until handshake.
  logic m_busy, m_done, m_sat;
  int   m_cnt, m_x, m_it, p_sat, p_x, p_it;

  always @(posedge clk or negedge rst_n) begin
    int a, b, c;
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_cnt <= 0;
      m_sat <= 0; m_x <= 0; m_it <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        ref_model(int'(req_s), int'(req_t), int'(req_mode), a, b, c);
        p_sat <= a; p_x <= b; p_it <= c;
        m_busy <= 1; m_cnt <= 0;
      end
    end else if (!m_done) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == (W+1) * p_it) begin
        m_done <= 1;
        m_sat <= p_sat[0]; m_x <= p_x; m_it <= p_it;
      end
    end else if (res_ready) begin
      m_busy <= 0; m_done <= 0;
    end
  end

  // Single compare process, every cycle.
  always @(negedge clk) begin
    chk("req_ready", int'(req_ready), int'(!m_busy));
    chk("res_valid", int'(res_valid), int'(m_done));
    chk("res_sat",   int'(res_sat),   int'(m_sat));
    chk("res_x",     int'(res_x),     m_x);
    chk("res_iters", int'(res_iters), m_it);
  end

  task automatic run_req(input int s, input int t, input int mode,
                         input int e_sat, input int e_x, input int e_it,
                         input int e_lat, input int hold, input bit poke);
    int lat;
    req_s = W'(s); req_t = W'(t); req_mode = 2'(mode); req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!res_valid && lat < 2 * (W+1) * N) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, e_lat);
    chk("d_sat", int'(res_sat), e_sat);
    chk("d_x", int'(res_x), e_x);
    chk("d_iters", int'(res_iters), e_it);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 3) begin
        req_s = 1; req_t = 0; req_mode = 2'b10; req_valid = 1;
      end else req_valid = 0;
      @(posedge clk); #1;
    end
    req_valid = 0;
    if (hold > 0) begin
      chk("stall_x", int'(res_x), e_x);
      chk("stall_iters", int'(res_iters), e_it);
      chk("stall_ready", int'(req_ready), 0);
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("post_hs_ready", int'(req_ready), 1);
  endtask

  initial begin
    int a, b, c;
    // pin the reference model to hand-computed values
    ref_model(3, 2, 0, a, b, c);  chk("m1_sat", a, 1); chk("m1_x", b, 2); chk("m1_it", c, 3);
    ref_model(0, 5, 0, a, b, c);  chk("m2_x", b, 5);   chk("m2_it", c, 6);
    ref_model(0, 5, 1, a, b, c);  chk("m3_x", b, 6);
    ref_model(5, 8, 0, a, b, c);  chk("m4_x", b, 0);   chk("m4_it", c, 1);
    ref_model(4, 7, 0, a, b, c);  chk("m5_sat", a, 0); chk("m5_it", c, 16);
    ref_model(9, 15, 3, a, b, c); chk("m6_sat", a, 0);

    #12 rst_n = 1;
    @(posedge clk); #1;

    // reset mid-search
    req_s = 4; req_t = 7; req_mode = 0; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_iters", int'(res_iters), 0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    run_req(3, 2, 0, 1, 2, 3, 15, 0, 0);

    // directed scenarios
    run_req(3, 2, 0, 1, 2, 3, 15, 2, 0);
    run_req(0, 5, 0, 1, 5, 6, 30, 0, 0);
    run_req(0, 5, 1, 1, 6, 7, 35, 0, 0);
    run_req(5, 8, 0, 1, 0, 1, 5, 0, 0);
    run_req(4, 7, 0, 0, 0, 16, 80, 0, 0);
    run_req(9, 15, 3, 0, 0, 16, 80, 1, 0);
    // backpressure with an ignored request during the stall
    run_req(3, 2, 0, 1, 2, 3, 15, 20, 1);
    run_req(7, 3, 2, 1, 3, 4, 20, 0, 0);

    // randomized requests
    for (int i = 0; i < 40; i++) begin
      int s, t, m;
      s = $urandom_range(0, N-1);
      t = $urandom_range(0, N-1);
      m = $urandom_range(0, 3);
      ref_model(s, t, m, a, b, c);
      run_req(s, t, m, a, b, c, (W+1) * c, $urandom_range(0, 3), 0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
